text_vram_engine: RTL and testbench

- Second-generation text VRAM: dual-port BRAM holding one DATA_WIDTH-bit cell per character position (character code plus attribute bits).
- Adds a hardware command engine for full-screen fill/clear and scroll-up-by-one-row.
- Sits between the CPU bus adapter and the character-generator/display pipeline.
- Display read port is never stalled. CPU port and engine share the second RAM port; the engine has priority while busy.

---
 rtl/text_vram_pkg.sv | 18 +
 rtl/text_vram_dpram.sv | 29 ++
 rtl/text_vram_engine.sv | 171 +++++++++++++++++
 tb/tb_text_vram_engine.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/text_vram_pkg.sv
// Shared definitions for the text VRAM engine: command opcodes, engine states
// and the blank-cell value (space on light grey).
package text_vram_pkg;

  localparam logic [1:0]  CMD_CLEAR     = 2'b00;
  localparam logic [1:0]  CMD_SCROLL_UP = 2'b01;
  localparam logic [15:0] DEFAULT_CELL  = 16'h0720;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_SCR_FILL,
    ST_FIN
  } state_t;

endpackage

// File: rtl/text_vram_dpram.sv
// Dual-port block RAM: port A read-only, port B read/write with read-first output.
// Every cell powers up as INIT_CELL.
module text_vram_dpram #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 4800,
  parameter int                    ADDR_WIDTH = 13,
  parameter logic [DATA_WIDTH-1:0] INIT_CELL  = '0
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_CELL};

  always_ff @(posedge clk) begin
    dout_a <= mem[addr_a];
  end

  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= din_b;
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/text_vram_engine.sv
// Text VRAM with a display read port, a CPU read/write port and a command engine
// (full-screen clear, scroll up by one row) that owns RAM port B while busy.
module text_vram_engine
  import text_vram_pkg::*;
#(
  parameter int                    COLS       = 80,
  parameter int                    ROWS       = 60,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 13,
  parameter logic [DATA_WIDTH-1:0] INIT_CELL  = DATA_WIDTH'(DEFAULT_CELL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  input  logic                  cpu_en,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_fill,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int                    MEM_SIZE   = COLS * ROWS;
  localparam logic [ADDR_WIDTH:0]   MEM_SIZE_X = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] COLS_A     = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] FILL_BASE  = ADDR_WIDTH'(MEM_SIZE - COLS);

  state_t                state_p, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt_p, cnt_nxt;
  logic [DATA_WIDTH-1:0] fill_p;

  logic                  eng_we;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [DATA_WIDTH-1:0] eng_din;

  logic [ADDR_WIDTH-1:0] ram_addr_a, ram_addr_b;
  logic                  ram_we_b;
  logic [DATA_WIDTH-1:0] ram_din_b, ram_dout_a, ram_dout_b;

  logic                  disp_in_rng, cpu_in_rng, cpu_acc;
  logic                  disp_ok_p, cpu_live_p, cpu_oob_p;
  logic [DATA_WIDTH-1:0] cpu_hold_p, cpu_live_data;

  assign busy      = (state_p == ST_CLR) || (state_p == ST_SCR_RD) ||
                     (state_p == ST_SCR_WR) || (state_p == ST_SCR_FILL);
  assign cpu_ready = !busy;
  assign cmd_ready = (state_p == ST_IDLE);
  assign done      = (state_p == ST_FIN);

  // Engine sequencing: cnt_p is the write address for CLR/SCR_FILL and the
  // source address for the scroll copy.
  always_comb begin
    state_nxt = state_p;
    cnt_nxt   = cnt_p;
    eng_we    = 1'b0;
    eng_addr  = cnt_p;
    eng_din   = fill_p;
    case (state_p)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_nxt = '0;
          case (cmd_op)
            CMD_CLEAR: state_nxt = ST_CLR;
            CMD_SCROLL_UP: begin
              if (ROWS == 1) begin
                state_nxt = ST_SCR_FILL;
                cnt_nxt   = FILL_BASE;
              end else begin
                state_nxt = ST_SCR_RD;
                cnt_nxt   = COLS_A;
              end
            end
            default: state_nxt = ST_FIN;
          endcase
        end
      end
      ST_CLR: begin
        eng_we = 1'b1;
        if (cnt_p == LAST_ADDR) state_nxt = ST_FIN;
        else                    cnt_nxt   = cnt_p + 1'b1;
      end
      ST_SCR_RD: state_nxt = ST_SCR_WR;
      ST_SCR_WR: begin
        eng_we   = 1'b1;
        eng_addr = cnt_p - COLS_A;
        eng_din  = ram_dout_b;
        if (cnt_p == LAST_ADDR) begin
          state_nxt = ST_SCR_FILL;
          cnt_nxt   = FILL_BASE;
        end else begin
          state_nxt = ST_SCR_RD;
          cnt_nxt   = cnt_p + 1'b1;
        end
      end
      ST_SCR_FILL: begin
        eng_we = 1'b1;
        if (cnt_p == LAST_ADDR) state_nxt = ST_FIN;
        else                    cnt_nxt   = cnt_p + 1'b1;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p <= ST_IDLE;
      cnt_p   <= '0;
    end else begin
      state_p <= state_nxt;
      cnt_p   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_ready) fill_p <= cmd_fill;
  end

  assign disp_in_rng = {1'b0, disp_addr} < MEM_SIZE_X;
  assign cpu_in_rng  = {1'b0, cpu_addr} < MEM_SIZE_X;
  assign cpu_acc     = cpu_en && cpu_ready;

  assign ram_addr_a = disp_in_rng ? disp_addr : '0;
  assign ram_addr_b = busy ? eng_addr : (cpu_in_rng ? cpu_addr : '0);
  assign ram_we_b   = busy ? eng_we : (cpu_acc && cpu_we && cpu_in_rng);
  assign ram_din_b  = busy ? eng_din : cpu_wdata;

  text_vram_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_CELL  (INIT_CELL)
  ) u_ram (
    .clk    (clk),
    .addr_a (ram_addr_a),
    .dout_a (ram_dout_a),
    .addr_b (ram_addr_b),
    .we_b   (ram_we_b),
    .din_b  (ram_din_b),
    .dout_b (ram_dout_b)
  );

  // Read-data stage: out-of-range reads show 0; cpu_rdata holds between accesses
  // because port B output is reused by the engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_ok_p  <= 1'b0;
      cpu_live_p <= 1'b0;
      cpu_oob_p  <= 1'b0;
      cpu_hold_p <= '0;
    end else begin
      disp_ok_p  <= disp_in_rng;
      cpu_live_p <= cpu_acc;
      if (cpu_acc)    cpu_oob_p  <= !cpu_in_rng;
      if (cpu_live_p) cpu_hold_p <= cpu_live_data;
    end
  end

  assign cpu_live_data = cpu_oob_p ? '0 : ram_dout_b;
  assign cpu_rdata     = cpu_live_p ? cpu_live_data : cpu_hold_p;
  assign disp_data     = disp_ok_p ? ram_dout_a : '0;

endmodule

// File: tb/tb_text_vram_engine.sv
// Randomized and directed bench for text_vram_engine on a 4x3 screen, checked
// against an array model of the screen.
module tb_text_vram_engine;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int N    = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          cpu_en = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_fill = '0;
  logic          cmd_ready, busy, done;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model [N];
  logic [DW-1:0] last_rd;

  text_vram_engine #(.COLS(COLS), .ROWS(ROWS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .disp_addr(disp_addr), .disp_data(disp_data),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_fill(cmd_fill), .cmd_ready(cmd_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp_check_all(input string tag);
    for (int a = 0; a < N; a++) begin
      disp_addr = AW'(a);
      tick();
      check($sformatf("%s disp[%0d]", tag, a), disp_data, model[a]);
    end
  endtask

  task automatic cpu_access(input logic we, input int a, input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] exp;
    exp = (a < N) ? model[a] : '0;
    cpu_en = 1'b1; cpu_we = we; cpu_addr = AW'(a); cpu_wdata = d;
    tick();
    cpu_en = 1'b0; cpu_we = 1'b0;
    check(tag, cpu_rdata, exp);
    last_rd = exp;
    if (we && a < N) model[a] = d;
  endtask

  // Issue a command and measure the busy window and done pulses; optionally
  // attempt a CPU write to address 0 while the engine is busy.
  task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] f, input int exp_busy,
                         input logic poke, input string tag);
    int n = 0;
    int dn = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_fill = f;
    tick();
    cmd_valid = 1'b0;
    while (busy && n < 500) begin
      n++;
      if (done) dn++;
      if (poke && n == 1) begin
        check({tag, " cpu_ready_busy"}, cpu_ready, 1'b0);
        cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = 16'h1234;
      end else if (poke && n == 2) begin
        cpu_en = 1'b0; cpu_we = 1'b0;
        check({tag, " rdata_hold"}, cpu_rdata, last_rd);
      end
      tick();
    end
    check({tag, " busy_cycles"}, n, exp_busy);
    check({tag, " cmd_ready_fin"}, cmd_ready, 1'b0);
    if (done) dn++;
    tick();
    if (done) dn++;
    check({tag, " done_pulses"}, dn, 1);
    check({tag, " cmd_ready_idle"}, cmd_ready, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) model[i] = 16'h0720;
    last_rd = '0;

    tick(); tick();
    check("rst disp_data", disp_data, 0);
    check("rst cpu_rdata", cpu_rdata, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rst_n = 1'b1;
    tick();
    check("idle cpu_ready", cpu_ready, 1);
    check("idle cmd_ready", cmd_ready, 1);
    check("idle busy", busy, 0);
    disp_check_all("init");

    cpu_access(1'b1, 5, 16'h1141, "wr5 readfirst");
    cpu_access(1'b0, 5, 16'h0000, "rd5");
    tick();
    check("rd5 hold", cpu_rdata, 16'h1141);
    disp_addr = 4'd5;
    tick();
    check("disp5", disp_data, 16'h1141);

    for (int it = 0; it < 80; it++) begin
      int r, a, da;
      logic [DW-1:0] d, exp_d;
      r = $urandom_range(0, 2);
      a = $urandom_range(0, 15);
      da = $urandom_range(0, 15);
      d = DW'($urandom);
      exp_d = (da < N) ? model[da] : '0;
      disp_addr = AW'(da);
      if (r == 2) begin
        tick();
        check("rnd idle_hold", cpu_rdata, last_rd);
      end else begin
        cpu_access(r == 0, a, d, "rnd cpu_rdata");
      end
      check("rnd disp", disp_data, exp_d);
    end

    for (int a = 0; a < N; a++) cpu_access(1'b1, a, DW'(a), "fill_addr");
    run_cmd(2'b01, 16'h0720, 2*COLS*(ROWS-1) + COLS, 1'b0, "scroll");
    for (int i = 0; i < N - COLS; i++) model[i] = model[i + COLS];
    for (int i = N - COLS; i < N; i++) model[i] = 16'h0720;
    disp_check_all("scroll");

    run_cmd(2'b00, 16'hABCD, N, 1'b1, "clear");
    for (int i = 0; i < N; i++) model[i] = 16'hABCD;
    disp_check_all("clear");

    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_fill = 16'h0000;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    tick();
    check("midrst done2", done, 0);
    rst_n = 1'b1;
    tick();
    check("midrst done3", done, 0);
    check("midrst cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 5; i++) model[i] = 16'h0000;
    disp_check_all("midrst");
    run_cmd(2'b10, 16'h5555, 0, 1'b0, "reserved");
    disp_check_all("reserved");

    cpu_access(1'b0, 3, 16'h0000, "rd3");
    cpu_access(1'b1, 12, 16'hDEAD, "oob wr");
    cpu_access(1'b0, 12, 16'h0000, "oob rd");
    disp_addr = 4'd15;
    tick();
    check("disp oob", disp_data, 0);
    disp_check_all("oob unchanged");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
